ex_muldiv_unit: RTL and testbench

//  Iterative 16-bit multiply/divide unit in the EX stage, directly downstream of the ID/EX buffer.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_step.sv | 35 +++
 rtl/ex_muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants, FSM state type and helpers for the EX-stage multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 16;
  localparam int unsigned COUNT_W      = $clog2(MULDIV_WIDTH);

  localparam logic [3:0] FUNCT_MUL   = 4'b0100;
  localparam logic [3:0] FUNCT_DIV   = 4'b0101;
  localparam logic [1:0] ALUOP_TYPEA = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } muldiv_state_e;

  function automatic logic is_muldiv(input logic [3:0] funct);
    return (funct == FUNCT_MUL) || (funct == FUNCT_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: shift-add for MUL, restoring
// trial-subtract for DIV. Accumulator is {high word, low word}.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    add_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]}
            + ({(WIDTH+1){acc_in[0]}} & {1'b0, operand});
    rem_sh  = acc_in[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, operand};
    if (is_div) begin
      // diff MSB is the borrow: clear means the trial subtract fits.
      if (!diff[WIDTH]) begin
        acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_out = {add_sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage; stalls the front end while iterating.
// Define MULDIV_SIGNED_EN for two's-complement operands (magnitudes iterated, sign fixed at DONE).
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ex_flush,
  input  logic [3:0]       funct_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam logic [COUNT_W-1:0] LastCount = COUNT_W'(WIDTH - 1);

  muldiv_state_e        state_q;
  logic [COUNT_W-1:0]   count_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opnd_q;
  logic                 is_div_q;
  logic                 neg_lo_q;
  logic                 neg_hi_q;
  logic [WIDTH-1:0]     result_lo_q;
  logic [WIDTH-1:0]     result_hi_q;
  logic                 done_q;
  logic                 dbz_q;

  logic                 accept;
  logic                 req_div;
  logic                 b_zero;
  logic                 sign_a;
  logic                 sign_b;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     fin_lo;
  logic [WIDTH-1:0]     fin_hi;

  assign accept  = ((state_q == StIdle) || (state_q == StDone)) && start && !ex_flush
                   && is_muldiv(funct_code);
  assign stall   = (state_q == StCalc) || accept;
  assign req_div = (funct_code == FUNCT_DIV);
  assign b_zero  = (op_b == '0);

  always_comb begin
`ifdef MULDIV_SIGNED_EN
    sign_a = op_a[WIDTH-1];
    sign_b = op_b[WIDTH-1];
    mag_a  = sign_a ? -op_a : op_a;
    mag_b  = sign_b ? -op_b : op_b;
`else
    sign_a = 1'b0;
    sign_b = 1'b0;
    mag_a  = op_a;
    mag_b  = op_b;
`endif
  end

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div  (is_div_q),
    .acc_in  (acc_q),
    .operand (opnd_q),
    .acc_out (acc_step)
  );

  // Sign fix applied to the final iteration's accumulator as it enters DONE.
  always_comb begin
    prod_fix = neg_lo_q ? -acc_step : acc_step;
    if (is_div_q) begin
      fin_lo = neg_lo_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
      fin_hi = neg_hi_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    end else begin
      fin_lo = prod_fix[WIDTH-1:0];
      fin_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      is_div_q    <= 1'b0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      result_lo_q <= '0;
      result_hi_q <= '0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            dbz_q    <= 1'b0;
            is_div_q <= req_div;
            count_q  <= '0;
            neg_lo_q <= sign_a ^ sign_b;
            neg_hi_q <= sign_a;
            if (req_div && b_zero) begin
              state_q     <= StDone;
              done_q      <= 1'b1;
              dbz_q       <= 1'b1;
              result_lo_q <= '1;
              result_hi_q <= op_a;
            end else begin
              state_q <= StCalc;
              // DIV shifts the dividend up through the low word; MUL shifts the multiplier out.
              acc_q   <= {{WIDTH{1'b0}}, (req_div ? mag_a : mag_b)};
              opnd_q  <= req_div ? mag_b : mag_a;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StCalc: begin
          acc_q   <= acc_step;
          count_q <= count_q + 1'b1;
          if (count_q == LastCount) begin
            state_q     <= StDone;
            count_q     <= '0;
            done_q      <= 1'b1;
            result_lo_q <= fin_lo;
            result_hi_q <= fin_hi;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign done        = done_q;
  assign result_lo   = result_lo_q;
  assign result_hi   = result_hi_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed cases plus random MUL/DIV against an
// arithmetic reference model. Honours MULDIV_SIGNED_EN to match the DUT build.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ex_flush;
  logic [3:0]  funct_code;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        stall;
  logic        done;
  logic [15:0] result_lo;
  logic [15:0] result_hi;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  ex_muldiv_unit #(
    .WIDTH (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ex_flush    (ex_flush),
    .funct_code  (funct_code),
    .op_a        (op_a),
    .op_b        (op_b),
    .stall       (stall),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operand values.
  task automatic model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] lo, output logic [15:0] hi, output logic dbz);
    logic [31:0] p;
`ifdef MULDIV_SIGNED_EN
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
`endif
    dbz = 1'b0;
    if (f == FUNCT_MUL) begin
`ifdef MULDIV_SIGNED_EN
      p = 32'(sa * sb);
`else
      p = {16'h0, a} * {16'h0, b};
`endif
      lo = p[15:0];
      hi = p[31:16];
    end else if (b == 16'h0) begin
      lo  = 16'hFFFF;
      hi  = a;
      dbz = 1'b1;
    end else begin
`ifdef MULDIV_SIGNED_EN
      if (a == 16'h8000 && b == 16'hFFFF) begin
        lo = 16'h8000;
        hi = 16'h0000;
      end else begin
        p  = 32'(sa / sb);
        lo = p[15:0];
        p  = 32'(sa % sb);
        hi = p[15:0];
      end
`else
      lo = a / b;
      hi = a % b;
`endif
    end
  endtask

  // Issue one operation and follow it for 20 cycles, checking stall window, done timing,
  // results and hold. Junk start/flush/operands are driven during CALC to prove they are ignored.
  task automatic run_op(input string tag, input logic [3:0] f, input logic [15:0] a,
                        input logic [15:0] b);
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
    logic        exp_dbz;
    int          exp_k;
    int          done_k;
    int          done_cnt;
    logic        stall_ok;
    logic [15:0] got_lo;
    logic [15:0] got_hi;
    logic        got_dbz;
    model(f, a, b, exp_lo, exp_hi, exp_dbz);
    exp_k    = exp_dbz ? 1 : 17;
    done_k   = 0;
    done_cnt = 0;
    stall_ok = 1'b1;
    got_lo   = '0;
    got_hi   = '0;
    got_dbz  = 1'b0;
    @(negedge clk);
    start = 1'b1; ex_flush = 1'b0; funct_code = f; op_a = a; op_b = b;
    #1 check({tag, "_stall_accept"}, 32'(stall), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_k == 0) begin
          done_k  = k;
          got_lo  = result_lo;
          got_hi  = result_hi;
          got_dbz = div_by_zero;
        end
      end
      if (k < exp_k && !stall) stall_ok = 1'b0;
      if (k >= exp_k && stall) stall_ok = 1'b0;
      if (exp_k == 17 && k <= 14) begin
        start      = 1'($urandom_range(0, 1));
        ex_flush   = 1'($urandom_range(0, 1));
        funct_code = 4'($urandom_range(4, 5));
        op_a       = 16'($urandom);
        op_b       = 16'($urandom);
      end else begin
        start    = 1'b0;
        ex_flush = 1'b0;
      end
    end
    check({tag, "_done_cycle"}, 32'(done_k), 32'(exp_k));
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_stall_window"}, 32'(stall_ok), 32'd1);
    check({tag, "_lo"}, 32'(got_lo), 32'(exp_lo));
    check({tag, "_hi"}, 32'(got_hi), 32'(exp_hi));
    check({tag, "_dbz"}, 32'(got_dbz), 32'(exp_dbz));
    check({tag, "_hold"}, {result_hi, result_lo}, {exp_hi, exp_lo});
  endtask

  // A start that must not be accepted: no stall, no done for 20 cycles.
  task automatic expect_no_accept(input string tag, input logic [3:0] f, input logic flush);
    int done_cnt;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1; ex_flush = flush; funct_code = f; op_a = 16'h1234; op_b = 16'h0003;
    #1 check({tag, "_stall"}, 32'(stall), 32'd0);
    @(posedge clk);
    #1 start = 1'b0; ex_flush = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check({tag, "_no_done"}, 32'(done_cnt), 32'd0);
  endtask

  initial begin
    logic [3:0]  rf;
    logic [15:0] ra;
    logic [15:0] rb;
    rst = 1'b1; start = 1'b0; ex_flush = 1'b0; funct_code = 4'h0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_lo", 32'(result_lo), 32'd0);
    check("rst_hi", 32'(result_hi), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    run_op("mul_3x7", FUNCT_MUL, 16'd3, 16'd7);
    run_op("mul_ffff", FUNCT_MUL, 16'hFFFF, 16'hFFFF);
    run_op("div_100_7", FUNCT_DIV, 16'd100, 16'd7);
    run_op("div_5_0", FUNCT_DIV, 16'd5, 16'd0);
    run_op("div_after_dbz", FUNCT_DIV, 16'hFFFF, 16'h0001);

    // Reset while CALC is at count 5 (cycle N+6).
    @(negedge clk);
    start = 1'b1; funct_code = FUNCT_MUL; op_a = 16'd9; op_b = 16'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_res", {result_hi, result_lo}, 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    run_op("mul_2x2", FUNCT_MUL, 16'd2, 16'd2);

    expect_no_accept("flush", FUNCT_MUL, 1'b1);
    expect_no_accept("bad_funct", 4'b0110, 1'b0);

`ifdef MULDIV_SIGNED_EN
    run_op("smul_m6x7", FUNCT_MUL, 16'hFFFA, 16'd7);
    check("smul_lit", {result_hi, result_lo}, 32'hFFFF_FFD6);
    run_op("sdiv_m7_2", FUNCT_DIV, 16'hFFF9, 16'd2);
    check("sdiv_lit", {result_hi, result_lo}, 32'hFFFF_FFFD);
    run_op("sdiv_min_m1", FUNCT_DIV, 16'h8000, 16'hFFFF);
`endif

    for (int i = 0; i < 24; i++) begin
      rf = ($urandom_range(0, 1) == 0) ? FUNCT_MUL : FUNCT_DIV;
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'h0000;
        1:       rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      run_op($sformatf("rnd%0d", i), rf, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
